acc_cpu_param: RTL and testbench
================================

Name: acc_cpu_param

Overview:
- Parametrised successor to the team's 4-bit accumulator CPU. Data width and memory depth are generic.
- Instructions are single-word and load into an internal program memory through a write port.
- Execution is a clean three-cycle FETCH/DECODE/EXECUTE FSM with Z/C flags, conditional branches, SLEEP/wakeup and a terminal HALT.
- Sits as the compute core under the assembler flow; the assembler emits words for the program-load port.

Parameters:
- DW, 4, data/accumulator width in bits. Must satisfy DW >= AW.
- AW, 4, address width. Program memory and data memory are each 2^AW words.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- wakeup  input  1  leaves SLEEP when sampled high at a clock edge.
- prog_we  input  1  program memory write enable.
- prog_addr  input  AW  program memory write address.
- prog_wdata  input  4+DW  instruction word: [DW+3:DW] is the opcode, [DW-1:0] is imm.
- acc  output  DW  accumulator.
- pc  output  AW  program counter.
- zero  output  1  Z flag.
- carry  output  1  C flag.
- sleeping  output  1  high while in SLEEP.
- halted  output  1  high while in HALT.

Behaviour:
- Reset (asynchronous): acc=0, pc=0, Z=0, C=0, IR=0, state=FETCH, sleeping=0, halted=0. Memory contents are not cleared.
- Program load: on a clk edge with prog_we=1, imem[prog_addr] <= prog_wdata.
  - Accepted in every state, including while reset is held.
  - A same-edge fetch of the same address returns the old word (read-before-write).
- States: FETCH -> DECODE -> EXECUTE -> FETCH. Every non-sleep, non-halt instruction takes exactly 3 cycles.
- FETCH: IR <= imem[pc]; pc <= pc+1, wrapping modulo 2^AW.
- DECODE: opcode and imm are latched from IR.
  - Opcode 8 goes to SLEEP.
  - Opcode D goes to HALT.
  - All other opcodes go to EXECUTE.
- EXECUTE: results commit on the EXECUTE edge, then the FSM returns to FETCH. A = imm[AW-1:0]; D = dmem[A].
  - 0 NOP: no change.
  - 1 LDI: acc <= imm; Z updated; C unchanged.
  - 2 ADD: {C,acc} <= acc + D (DW+1-bit sum); Z updated.
  - 3 SUB: acc <= acc - D (mod 2^DW); C = 1 iff acc < D (borrow); Z updated.
  - 4 AND: acc <= acc & D; Z updated; C <= 0.
  - 5 OR: acc <= acc | D; Z updated; C <= 0.
  - 6 STA: dmem[A] <= acc; flags unchanged.
  - 7 XNOR: acc <= ~(acc ^ D); Z updated; C <= 0.
  - 9 JMP: pc <= A.
  - A JZ: pc <= A if Z=1; otherwise no change.
  - B JC: pc <= A if C=1; otherwise no change.
  - C LDA: acc <= D; Z updated; C unchanged.
  - E, F: treated as NOP.
- Z is set iff the new acc == 0.
- SLEEP: sleeping=1, pc holds (it already points past the SLP).
  - Edge with wakeup=1: go to FETCH, sleeping=0.
  - wakeup in any other state is ignored.
- HALT: halted=1. Only reset exits HALT. wakeup is ignored.
- Reset mid-instruction: takes effect immediately. No partial dmem/acc commit after the reset edge.
- Wrap-around: a fetch at pc=2^AW-1 yields pc=0.

Test Plan:
- Load imem {0:LDI 5, 1:STA 2, 2:LDI 3, 3:ADD 2, 4:HLT}, release reset.
  - Required: acc=3 at cycle 9 (counting from the first edge after reset), acc=8 at cycle 12, halted=1 at cycle 14.
  - Required: Z=0, C=0.
- Carry and zero: dmem[1]=9 (via LDI 9 then STA 1), then LDI 7, ADD 1 -> acc=0, C=1, Z=1. Follow with JC 8 -> pc=8 after EXECUTE.
- Borrow: dmem[0]=6, LDI 2, SUB 0 -> acc=12, C=1, Z=0. Follow with JZ 0 -> not taken; pc advances sequentially.
- Sleep: program {LDI 1, SLP, LDI 2, HLT}.
  - Required: sleeping=1 with acc=1 and pc=2.
  - Hold wakeup=0 for 10 cycles -> no change.
  - Pulse wakeup for one cycle -> acc=2 three cycles after the FETCH, then halted=1.
- Reset mid-EXECUTE of STA 3 (acc=0xA) -> state=FETCH, pc=0, acc=0, and dmem[3] keeps its old value.
- Wrap and JMP: imem[15]=JMP 15 with pc starting at 14 (NOP).
  - Required: pc sequence 14 -> 15 -> 0 -> 15, with no X on any output.
  - prog_we writing imem[0] during this loop must not disturb execution.

Source files
------------

// File: rtl/acc_cpu_param_if.sv
// Program-load, wakeup and architectural status signals of the accumulator CPU.
// The master side loads programs and observes the core; the slave side is the core.
interface acc_cpu_param_if #(
  parameter int DW = 4,
  parameter int AW = 4
);
  logic            wakeup;
  logic            prog_we;
  logic [AW-1:0]   prog_addr;
  logic [DW+3:0]   prog_wdata;
  logic [DW-1:0]   acc;
  logic [AW-1:0]   pc;
  logic            zero;
  logic            carry;
  logic            sleeping;
  logic            halted;

  modport master (
    output wakeup, prog_we, prog_addr, prog_wdata,
    input  acc, pc, zero, carry, sleeping, halted
  );

  modport slave (
    input  wakeup, prog_we, prog_addr, prog_wdata,
    output acc, pc, zero, carry, sleeping, halted
  );
endinterface

// File: rtl/acc_cpu_param.sv
// Parametrised accumulator CPU: FETCH/DECODE/EXECUTE with Z/C flags, branches,
// SLEEP/wakeup and HALT. Program memory is loaded through a write port.
module acc_cpu_param #(
  parameter int DW = 4,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  acc_cpu_param_if.slave bus
);
  localparam int DEPTH = 1 << AW;
  localparam int IW    = DW + 4;

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_EXECUTE = 3'd2;
  localparam logic [2:0] S_SLEEP   = 3'd3;
  localparam logic [2:0] S_HALT    = 3'd4;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_STA  = 4'h6;
  localparam logic [3:0] OP_XNOR = 4'h7;
  localparam logic [3:0] OP_SLP  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_JC   = 4'hB;
  localparam logic [3:0] OP_LDA  = 4'hC;
  localparam logic [3:0] OP_HLT  = 4'hD;

  localparam logic [AW-1:0] PC_ONE = 1;

  logic [IW-1:0] r_imem [DEPTH];
  logic [DW-1:0] r_dmem [DEPTH];

  logic [2:0]    r_state;
  logic [IW-1:0] r_ir;
  logic [3:0]    r_op;
  logic [DW-1:0] r_imm;
  logic [DW-1:0] r_acc;
  logic [AW-1:0] r_pc;
  logic          r_z;
  logic          r_c;

  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_d;
  logic [DW:0]   w_sum;
  logic [3:0]    w_ir_op;
  logic [DW-1:0] w_acc_n;
  logic          w_c_n;
  logic          w_acc_wr;
  logic [AW-1:0] w_pc_n;

  assign w_addr  = r_imm[AW-1:0];
  assign w_d     = r_dmem[w_addr];
  assign w_sum   = {1'b0, r_acc} + {1'b0, w_d};
  assign w_ir_op = r_ir[IW-1:DW];

  always_comb begin
    w_acc_n  = r_acc;
    w_c_n    = r_c;
    w_acc_wr = 1'b0;
    w_pc_n   = r_pc;
    case (r_op)
      OP_LDI:  begin w_acc_n = r_imm;            w_acc_wr = 1'b1; end
      OP_ADD:  begin {w_c_n, w_acc_n} = w_sum;   w_acc_wr = 1'b1; end
      OP_SUB:  begin
        w_acc_n  = r_acc - w_d;
        w_c_n    = (r_acc < w_d);
        w_acc_wr = 1'b1;
      end
      OP_AND:  begin w_acc_n = r_acc & w_d;      w_c_n = 1'b0; w_acc_wr = 1'b1; end
      OP_OR:   begin w_acc_n = r_acc | w_d;      w_c_n = 1'b0; w_acc_wr = 1'b1; end
      OP_XNOR: begin w_acc_n = ~(r_acc ^ w_d);   w_c_n = 1'b0; w_acc_wr = 1'b1; end
      OP_LDA:  begin w_acc_n = w_d;              w_acc_wr = 1'b1; end
      OP_JMP:  w_pc_n = w_addr;
      OP_JZ:   if (r_z) w_pc_n = w_addr;
      OP_JC:   if (r_c) w_pc_n = w_addr;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_ir    <= '0;
      r_op    <= '0;
      r_imm   <= '0;
      r_acc   <= '0;
      r_pc    <= '0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_ir    <= r_imem[r_pc];
          r_pc    <= r_pc + PC_ONE;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_op  <= w_ir_op;
          r_imm <= r_ir[DW-1:0];
          if (w_ir_op == OP_SLP)      r_state <= S_SLEEP;
          else if (w_ir_op == OP_HLT) r_state <= S_HALT;
          else                        r_state <= S_EXECUTE;
        end
        S_EXECUTE: begin
          r_acc <= w_acc_n;
          r_c   <= w_c_n;
          r_pc  <= w_pc_n;
          if (w_acc_wr) r_z <= (w_acc_n == '0);
          r_state <= S_FETCH;
        end
        S_SLEEP: if (bus.wakeup) r_state <= S_FETCH;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Memories are never cleared; program load stays live even while reset is held.
  always_ff @(posedge clk) begin
    if (bus.prog_we) r_imem[bus.prog_addr] <= bus.prog_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset && r_state == S_EXECUTE && r_op == OP_STA) r_dmem[w_addr] <= r_acc;
  end

  assign bus.acc      = r_acc;
  assign bus.pc       = r_pc;
  assign bus.zero     = r_z;
  assign bus.carry    = r_c;
  assign bus.sleeping = (r_state == S_SLEEP);
  assign bus.halted   = (r_state == S_HALT);
endmodule

// File: tb/tb_acc_cpu_param.sv
// Scoreboard bench for acc_cpu_param: an instruction-level reference model predicts
// architectural state at each commit cycle; a monitor compares at those cycles.
module tb_acc_cpu_param;
  localparam int DW    = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int MAXC  = 256;

  logic clk = 1'b0;
  logic reset = 1'b1;

  acc_cpu_param_if #(.DW(DW), .AW(AW)) bus();

  acc_cpu_param #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int tid;
    int acc;
    int pc;
    bit z;
    bit c;
    bit slp;
    bit hlt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  int prog_w [DEPTH];
  int m_imem [DEPTH];
  int m_dmem [DEPTH];
  bit wk     [MAXC];
  bit wr_en  [MAXC];
  int wr_a   [MAXC];
  int wr_d   [MAXC];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(input int c_, input int tid, input int acc, input int pc,
                               input int z, input int c, input int slp, input int hlt);
    exp_t e;
    e.cyc = c_; e.tid = tid; e.acc = acc; e.pc = pc;
    e.z = (z != 0); e.c = (c != 0); e.slp = (slp != 0); e.hlt = (hlt != 0);
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [DW+AW+3:0] got, want;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL missed t%0d expected at cycle %0d (now %0d)", e.tid, e.cyc, cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      got  = {bus.acc, bus.pc, bus.zero, bus.carry, bus.sleeping, bus.halted};
      want = {e.acc[DW-1:0], e.pc[AW-1:0], e.z, e.c, e.slp, e.hlt};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL state t%0d cyc %0d got acc=%h pc=%h z=%b c=%b slp=%b hlt=%b want acc=%h pc=%h z=%b c=%b slp=%b hlt=%b",
                 e.tid, cyc, got[DW+AW+3:AW+4], got[AW+3:4], got[3], got[2], got[1], got[0],
                 want[DW+AW+3:AW+4], want[AW+3:4], want[3], want[2], want[1], want[0]);
      end
    end
  end

  // Architectural model: walks instructions, stamping each commit with its cycle number.
  task automatic model(input int tid, input int limit, input int sleep_d, input int base);
    int pc, acc, z, c, t, app, w, op, imm, a, d, s, dl, sum;
    pc = 0; acc = 0; z = 0; c = 0; t = 0; app = 0;
    for (int k = 0; k < DEPTH; k++) m_imem[k] = prog_w[k];
    while (1) begin
      if (t + 1 > limit) break;
      while (app < t) begin
        app++;
        if (wr_en[app]) m_imem[wr_a[app]] = wr_d[app];
      end
      w   = m_imem[pc];
      pc  = (pc + 1) % DEPTH;
      op  = (w >> DW) & 15;
      imm = w & ((1 << DW) - 1);
      a   = imm % DEPTH;
      d   = m_dmem[a];
      s   = t + 2;
      if (s > limit) break;
      if (op == 8) begin
        push(base + s, tid, acc, pc, z, c, 1, 0);
        dl = (sleep_d > 0) ? sleep_d : int'($urandom_range(1, 6));
        for (int k = s + 1; k < s + dl && k < MAXC; k++) wk[k] = 1'b0;
        if (s + dl < MAXC) wk[s + dl] = 1'b1;
        if (dl >= 2 && s + dl - 1 <= limit) push(base + s + dl - 1, tid, acc, pc, z, c, 1, 0);
        t = s + dl;
        continue;
      end
      if (op == 13) begin
        push(base + s, tid, acc, pc, z, c, 0, 1);
        if (limit > s) push(base + limit, tid, acc, pc, z, c, 0, 1);
        break;
      end
      if (t + 3 > limit) break;
      case (op)
        1:  begin acc = imm; z = (acc == 0); end
        2:  begin sum = acc + d; c = (sum > 15); acc = sum & 15; z = (acc == 0); end
        3:  begin c = (acc < d); acc = (acc - d) & 15; z = (acc == 0); end
        4:  begin acc = acc & d; c = 0; z = (acc == 0); end
        5:  begin acc = acc | d; c = 0; z = (acc == 0); end
        6:  m_dmem[a] = acc;
        7:  begin acc = (~(acc ^ d)) & 15; c = 0; z = (acc == 0); end
        9:  pc = a;
        10: if (z != 0) pc = a;
        11: if (c != 0) pc = a;
        12: begin acc = d; z = (acc == 0); end
        default: ;
      endcase
      t = t + 3;
      push(base + t, tid, acc, pc, z, c, 0, 0);
    end
  endtask

  task automatic check_reset(input int tid);
    logic [DW+AW+3:0] got;
    got = {bus.acc, bus.pc, bus.zero, bus.carry, bus.sleeping, bus.halted};
    n_cmp++;
    if (got !== '0) begin
      n_bad++;
      $display("FAIL reset t%0d got %h want 0", tid, got);
    end
  endtask

  // Loads prog_w under reset, runs exactly `limit` cycles, then re-asserts reset.
  task automatic run(input int tid, input int limit, input int sleep_d,
                     input bit wk_noise, input int wrmode);
    int base;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      bus.prog_we = 1'b1; bus.prog_addr = AW'(k); bus.prog_wdata = (DW+4)'(prog_w[k]);
      @(posedge clk);
    end
    @(negedge clk);
    bus.prog_we = 1'b0;
    for (int k = 0; k < MAXC; k++) begin
      wk[k]    = wk_noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      wr_en[k] = 1'b0; wr_a[k] = 0; wr_d[k] = 0;
      if (wrmode == 1 && k >= 4) begin
        wr_en[k] = 1'b1; wr_d[k] = int'($urandom_range(0, 255));
      end
      if (wrmode == 2) begin
        wr_en[k] = ($urandom_range(0, 7) == 0);
        wr_a[k]  = int'($urandom_range(0, DEPTH - 1));
        wr_d[k]  = int'($urandom_range(0, 255));
      end
    end
    reset = 1'b0;
    base  = cyc;
    model(tid, limit, sleep_d, base);
    for (int n = 1; n <= limit; n++) begin
      bus.wakeup     = wk[n];
      bus.prog_we    = wr_en[n];
      bus.prog_addr  = AW'(wr_a[n]);
      bus.prog_wdata = (DW+4)'(wr_d[n]);
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    bus.wakeup = 1'b0; bus.prog_we = 1'b0;
    reset = 1'b1;
    #1;
    check_reset(tid);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL pending t%0d got %0d entries left want 0", tid, sb.size());
      sb.delete();
    end
  endtask

  task automatic clear_prog();
    for (int k = 0; k < DEPTH; k++) prog_w[k] = 0;
  endtask

  initial begin
    int idx, v, lim;
    bus.wakeup = 1'b0; bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_wdata = '0;
    for (int k = 0; k < DEPTH; k++) m_dmem[k] = 0;
    #1;
    check_reset(0);

    clear_prog();
    prog_w[0] = 'h15; prog_w[1] = 'h62; prog_w[2] = 'h13; prog_w[3] = 'h22; prog_w[4] = 'hD0;
    run(1, 20, 0, 1'b0, 0);

    clear_prog();
    prog_w[0] = 'h19; prog_w[1] = 'h61; prog_w[2] = 'h17; prog_w[3] = 'h21; prog_w[4] = 'hB8;
    for (int k = 5; k < 8; k++) prog_w[k] = 'hD0;
    prog_w[8] = 'hD0;
    run(2, 40, 0, 1'b1, 0);

    clear_prog();
    prog_w[0] = 'h16; prog_w[1] = 'h60; prog_w[2] = 'h12; prog_w[3] = 'h30; prog_w[4] = 'hA0;
    prog_w[5] = 'hD0;
    run(3, 30, 0, 1'b1, 0);

    clear_prog();
    prog_w[0] = 'h11; prog_w[1] = 'h80; prog_w[2] = 'h12; prog_w[3] = 'hD0;
    run(4, 40, 11, 1'b0, 0);

    clear_prog();
    prog_w[0] = 'h9E; prog_w[14] = 'h00; prog_w[15] = 'h9F;
    run(6, 30, 0, 1'b1, 1);

    for (int r = 0; r < 3; r++) begin
      clear_prog();
      idx = 0;
      for (int a = r * 7; a < r * 7 + 7 && a < DEPTH; a++) begin
        v = (a == 3) ? 5 : int'($urandom_range(0, 15));
        prog_w[idx] = 'h10 | v;  idx++;
        prog_w[idx] = 'h60 | a;  idx++;
      end
      prog_w[idx] = 'hD0;
      run(10 + r, 3 * idx + 8, 0, 1'b1, 0);
    end

    clear_prog();
    prog_w[0] = 'h1A; prog_w[1] = 'h63; prog_w[2] = 'hD0;
    run(5, 5, 0, 1'b0, 0);
    clear_prog();
    prog_w[0] = 'hC3; prog_w[1] = 'hD0;
    run(7, 12, 0, 1'b0, 0);

    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < DEPTH; k++) prog_w[k] = int'($urandom_range(0, 255));
      lim = int'($urandom_range(30, 100));
      run(100 + r, lim, 0, 1'b1, 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
